// File: rtl/snake_move_sequencer.sv
// Snake game sequencer: move-tick prescaler, direction latch, IDLE/RUN/DEAD play FSM, length/score.
// Optional `SNAKE_WRAP_EN: wall exits wrap to the opposite edge instead of ending the game.
module snake_move_sequencer #(
  parameter int TICK_DIV = 1000000,
  parameter int START_X  = 20,
  parameter int START_Y  = 20,
  parameter int X_MAX    = 383,
  parameter int Y_MAX    = 255,
  parameter int MAX_LEN  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        food_eaten,
  output logic [8:0]  xpos,
  output logic [8:0]  ypos,
  output logic        move_tick,
  output logic [5:0]  snake_len,
  output logic [15:0] score,
  output logic        running,
  output logic        game_over
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  typedef enum logic [1:0] {D_RIGHT = 2'd0, D_LEFT = 2'd1, D_UP = 2'd2, D_DOWN = 2'd3} dir_t;

  state_t        state, state_nx;
  dir_t          dir, pend_dir, btn_dir;
  logic          btn_vld, btn_rev;
  logic          start_s1, start_s2, start_rise;
  logic          step, step_ok;
  logic [CW-1:0] cnt;
  logic [9:0]    nx, ny;
  logic          x_oob, y_oob;
  logic [8:0]    x_new, y_new;

  assign start_rise = start_s1 & ~start_s2;
  assign step       = (state == RUN) && (cnt == CNT_LAST);
  assign running    = (state == RUN);
  assign game_over  = (state == DEAD);

  always_comb begin
    btn_vld = 1'b1;
    btn_dir = D_RIGHT;
    if (btn_up)         btn_dir = D_UP;
    else if (btn_down)  btn_dir = D_DOWN;
    else if (btn_left)  btn_dir = D_LEFT;
    else if (btn_right) btn_dir = D_RIGHT;
    else                btn_vld = 1'b0;
    // Same axis, different sense: a straight reversal into the body.
    btn_rev = (btn_dir[1] == dir[1]) && (btn_dir[0] != dir[0]);
  end

  // 10-bit so that stepping below zero shows up as a large out-of-range value.
  always_comb begin
    nx = {1'b0, xpos};
    ny = {1'b0, ypos};
    case (pend_dir)
      D_UP:    ny = ny - 10'd1;
      D_DOWN:  ny = ny + 10'd1;
      D_LEFT:  nx = nx - 10'd1;
      default: nx = nx + 10'd1;
    endcase
    x_oob = nx > 10'(X_MAX);
    y_oob = ny > 10'(Y_MAX);
`ifdef SNAKE_WRAP_EN
    x_new   = x_oob ? ((nx == 10'(X_MAX + 1)) ? 9'd0 : 9'(X_MAX)) : nx[8:0];
    y_new   = y_oob ? ((ny == 10'(Y_MAX + 1)) ? 9'd0 : 9'(Y_MAX)) : ny[8:0];
    step_ok = 1'b1;
`else
    x_new   = nx[8:0];
    y_new   = ny[8:0];
    step_ok = !(x_oob || y_oob);
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_rise) state_nx = RUN;
      RUN:     if (step && !step_ok) state_nx = DEAD;
      DEAD:    if (start_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      xpos      <= 9'(START_X);
      ypos      <= 9'(START_Y);
      move_tick <= 1'b0;
      snake_len <= 6'd1;
      score     <= 16'd0;
      dir       <= D_RIGHT;
      pend_dir  <= D_RIGHT;
      cnt       <= '0;
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
    end else begin
      start_s1  <= start;
      start_s2  <= start_s1;
      move_tick <= 1'b0;
      if (state == RUN) begin
        cnt <= step ? '0 : cnt + CW'(1);
        if (btn_vld && !btn_rev) pend_dir <= btn_dir;
        if (food_eaten) begin
          score <= score + 16'd1;
          if (snake_len < 6'(MAX_LEN)) snake_len <= snake_len + 6'd1;
        end
        if (step) begin
          dir <= pend_dir;
          if (step_ok) begin
            xpos      <= x_new;
            ypos      <= y_new;
            move_tick <= 1'b1;
          end
        end
      end
      if ((state == DEAD) && start_rise) begin
        xpos      <= 9'(START_X);
        ypos      <= 9'(START_Y);
        dir       <= D_RIGHT;
        pend_dir  <= D_RIGHT;
        snake_len <= 6'd1;
        score     <= 16'd0;
        cnt       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snake_move_sequencer.sv
// Bench for snake_move_sequencer: directed vector table, corner sequences, random run against a model.
module tb_snake_move_sequencer;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, bu, bd, bl, br, food;
  logic [8:0] x, y;
  logic tick, run, go;
  logic [5:0] len;
  logic [15:0] sc;

  logic start2, bu2, food2, zero;
  logic [8:0] x2, y2;
  logic tick2, run2, go2;
  logic [5:0] len2;
  logic [15:0] sc2;

  snake_move_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start(start), .btn_up(bu), .btn_down(bd), .btn_left(bl),
    .btn_right(br), .food_eaten(food), .xpos(x), .ypos(y), .move_tick(tick),
    .snake_len(len), .score(sc), .running(run), .game_over(go));

  snake_move_sequencer #(.TICK_DIV(TD), .START_Y(0)) dut0 (
    .clk(clk), .reset(reset), .start(start2), .btn_up(bu2), .btn_down(zero), .btn_left(zero),
    .btn_right(zero), .food_eaten(food2), .xpos(x2), .ypos(y2), .move_tick(tick2),
    .snake_len(len2), .score(sc2), .running(run2), .game_over(go2));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: game rules in plain integers, advanced once per rising edge.
  int m_mode, m_x, m_y, m_head, m_want, m_phase, m_len, m_score, m_tick, m_h1, m_h2;

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  always @(posedge clk) begin
    int old_mode, req, nx, ny, new_head;
    bit accept, stepped;
    if (!reset) begin
      m_mode = 0; m_x = 20; m_y = 20; m_head = 0; m_want = 0; m_phase = 0;
      m_len = 1; m_score = 0; m_tick = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      old_mode = m_mode;
      m_tick = 0;
      if (old_mode == 1) begin
        if (food) begin
          m_score = (m_score + 1) % 65536;
          if (m_len < 63) m_len = m_len + 1;
        end
        req = bu ? 2 : bd ? 3 : bl ? 1 : br ? 0 : -1;
        accept = (req >= 0) && (req != opp(m_head));
        stepped = (m_phase == TD - 1);
        new_head = m_head;
        if (stepped) begin
          m_phase = 0;
          nx = m_x; ny = m_y;
          case (m_want)
            0: nx = nx + 1;
            1: nx = nx - 1;
            2: ny = ny - 1;
            default: ny = ny + 1;
          endcase
          if (nx >= 0 && nx <= 383 && ny >= 0 && ny <= 255) begin
            m_x = nx; m_y = ny; m_tick = 1;
          end else begin
`ifdef SNAKE_WRAP_EN
            m_x = (nx > 383) ? 0 : (nx < 0) ? 383 : nx;
            m_y = (ny > 255) ? 0 : (ny < 0) ? 255 : ny;
            m_tick = 1;
`else
            m_mode = 2;
`endif
          end
          new_head = m_want;
        end else begin
          m_phase = m_phase + 1;
        end
        m_head = new_head;
        if (accept) m_want = req;
      end
      if (m_h1 == 1 && m_h2 == 0) begin
        if (old_mode == 0) m_mode = 1;
        else if (old_mode == 2) begin
          m_mode = 0; m_x = 20; m_y = 20; m_head = 0; m_want = 0;
          m_len = 1; m_score = 0; m_phase = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = start;
    end
  end

  typedef struct {
    logic [5:0] in;   // {start, up, down, left, right, food}
    int ncyc;
    int ex, ey, elen, esc, erun, etick;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] in, input int ncyc, input int ex, input int ey,
                              input int elen, input int esc, input int erun, input int etick);
    vec_t v;
    v.in = in; v.ncyc = ncyc; v.ex = ex; v.ey = ey;
    v.elen = elen; v.esc = esc; v.erun = erun; v.etick = etick;
    return v;
  endfunction

  task automatic drive(input logic [5:0] in);
    {start, bu, bd, bl, br, food} = in;
  endtask

  task automatic chk_main(input string p, input int ex, input int ey, input int elen,
                          input int esc, input int erun, input int ego, input int etick);
    chk({p, ".x"}, 64'(x), 64'(ex));
    chk({p, ".y"}, 64'(y), 64'(ey));
    chk({p, ".len"}, 64'(len), 64'(elen));
    chk({p, ".score"}, 64'(sc), 64'(esc));
    chk({p, ".running"}, 64'(run), 64'(erun));
    chk({p, ".game_over"}, 64'(go), 64'(ego));
    chk({p, ".move_tick"}, 64'(tick), 64'(etick));
  endtask

  vec_t tbl[12];
  int ticks_seen;
  bit hit;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(6'b100000, 2, 20, 20, 1, 0, 1, 0);
    tbl[1]  = mk(6'b000000, 4, 21, 20, 1, 0, 1, 1);
    tbl[2]  = mk(6'b000000, 4, 22, 20, 1, 0, 1, 1);
    tbl[3]  = mk(6'b000000, 1, 22, 20, 1, 0, 1, 0);
    tbl[4]  = mk(6'b000100, 3, 23, 20, 1, 0, 1, 1);
    tbl[5]  = mk(6'b010000, 4, 23, 19, 1, 0, 1, 1);
    tbl[6]  = mk(6'b010010, 4, 23, 18, 1, 0, 1, 1);
    tbl[7]  = mk(6'b000001, 1, 23, 18, 2, 1, 1, 0);
    tbl[8]  = mk(6'b000100, 3, 22, 18, 2, 1, 1, 1);
    tbl[9]  = mk(6'b000010, 4, 21, 18, 2, 1, 1, 1);
    tbl[10] = mk(6'b001001, 4, 21, 19, 6, 5, 1, 1);
    tbl[11] = mk(6'b000000, 2, 21, 19, 6, 5, 1, 0);

    zero = 1'b0; start2 = 1'b0; bu2 = 1'b0; food2 = 1'b0;
    drive(6'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_main("in_reset", 20, 20, 1, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_main("post_reset", 20, 20, 1, 0, 0, 0, 0);
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    chk("idle_no_tick", 64'(ticks_seen), 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].in);
      repeat (tbl[i].ncyc) @(posedge clk);
      @(negedge clk);
      chk_main($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].elen, tbl[i].esc,
               tbl[i].erun, 0, tbl[i].etick);
    end
    drive(6'b0);

    // Food in IDLE is dropped; 65 pulses in RUN saturate length.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    food = 1'b1;
    @(negedge clk);
    food = 1'b0;
    @(negedge clk);
    chk("idle_food.score", 64'(sc), 64'd0);
    chk("idle_food.len", 64'(len), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      hit = run;
    end
    chk("food_run_wait", 64'(run), 64'd1);
    for (int i = 0; i < 65; i++) begin
      food = 1'b1;
      @(negedge clk);
      food = 1'b0;
      @(negedge clk);
    end
    chk("food65.score", 64'(sc), 64'd65);
    chk("food65.len", 64'(len), 64'd63);

    // Reset while the prescaler sits at 2 must discard everything.
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      hit = tick;
    end
    chk("mid_run_tick_wait", 64'(tick), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_main("mid_run_reset", 20, 20, 1, 0, 0, 0, 0);
    reset = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    chk("after_reset_no_tick", 64'(ticks_seen), 64'd0);

    // Top wall with START_Y=0.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    chk("wall.run_entry", 64'(run2), 64'd1);
    food2 = 1'b1;
    @(negedge clk);
    food2 = 1'b0;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      hit = tick2;
    end
    chk("wall.first_step_x", 64'(x2), 64'd21);
    bu2 = 1'b1;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      hit = tick2 || go2;
    end
    bu2 = 1'b0;
    chk("wall.x", 64'(x2), 64'd21);
    chk("wall.score", 64'(sc2), 64'd1);
`ifdef SNAKE_WRAP_EN
    chk("wall.y", 64'(y2), 64'd255);
    chk("wall.running", 64'(run2), 64'd1);
    chk("wall.game_over", 64'(go2), 64'd0);
    chk("wall.move_tick", 64'(tick2), 64'd1);
`else
    chk("wall.y", 64'(y2), 64'd0);
    chk("wall.running", 64'(run2), 64'd0);
    chk("wall.game_over", 64'(go2), 64'd1);
    chk("wall.move_tick", 64'(tick2), 64'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    chk("restart.running", 64'(run2), 64'd0);
    chk("restart.game_over", 64'(go2), 64'd0);
    chk("restart.x", 64'(x2), 64'd20);
    chk("restart.y", 64'(y2), 64'd0);
    chk("restart.score", 64'(sc2), 64'd0);
    chk("restart.len", 64'(len2), 64'd1);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    chk("restart.run_again", 64'(run2), 64'd1);
`endif

    // Random play against the model.
    drive(6'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      chk($sformatf("rand%0d", i), {21'd0, x, y, tick, len, sc, run, go},
          {21'd0, 9'(m_x), 9'(m_y), 1'(m_tick), 6'(m_len), 16'(m_score),
           1'(m_mode == 1), 1'(m_mode == 2)});
      if ($urandom_range(0, 29) == 0) start = ~start;
      food = ($urandom_range(0, 7) == 0);
      bu = ($urandom_range(0, 5) == 0);
      bd = ($urandom_range(0, 7) == 0);
      bl = ($urandom_range(0, 6) == 0);
      br = ($urandom_range(0, 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snake_move_sequencer.md
# snake_move_sequencer

Game-level sequencer that drives the head position into `food_and_camera`. It owns the move-tick prescaler, the direction latch, and the play state machine (idle / run / dead), and it counts food eaten into length and score. It sits between the button inputs and `food_and_camera`: its `xpos`/`ypos` feed that block, and that block's `food_eaten` pulse feeds back into it.

## Interface
- `TICK_DIV`, 1000000: clk cycles per head step; legal range 2..2^24.
- `START_X`, 20: head X after reset or restart.
- `START_Y`, 20: head Y after reset or restart.
- `X_MAX`, 383: largest legal head X.
- `Y_MAX`, 255: largest legal head Y.
- `MAX_LEN`, 63: length saturation value; must be ≤ 63.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: level input; edge-detected internally.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: direction requests, level-sampled.
- `food_eaten` in 1: one-cycle pulse from `food_and_camera`.
- `xpos`, `ypos` out 9: head position.
- `move_tick` out 1: one-cycle pulse in the cycle after each head step.
- `snake_len` out 6: current length, 1..MAX_LEN.
- `score` out 16: food count, wraps modulo 2^16.
- `running` out 1: high in RUN.
- `game_over` out 1: high in DEAD.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DEAD.
- State transitions:
  - `start` rising edge in IDLE → RUN. Counters are not cleared on this transition.
  - `start` rising edge in DEAD → IDLE, with restart init: position ← (START_X, START_Y), dir ← RIGHT, `snake_len` ← 1, `score` ← 0, prescaler ← 0.
- Direction latch:
  - Encoding: RIGHT=0, LEFT=1, UP=2, DOWN=3.
  - Buttons are sampled every cycle in RUN into `pend_dir`.
  - Priority when several are held: up > down > left > right.
  - A request opposite to the committed `dir` is ignored.
  - `pend_dir` is committed to `dir` only at a step.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in RUN, then wraps to 0.
  - Holds its value in IDLE and DEAD.
  - A step occurs in the cycle where the count equals TICK_DIV-1.
- Step:
  - The next position is computed from the committed `pend_dir`: UP = y-1, DOWN = y+1, LEFT = x-1, RIGHT = x+1.
  - If the next position is in range (0..X_MAX, 0..Y_MAX), it is registered.
  - If out of range, the position holds and the state → DEAD.
  - All position arithmetic is 10-bit, so that underflow below 0 is detectable.
- Food:
  - `food_eaten` is honoured only in RUN.
  - `score` += 1.
  - `snake_len` += 1, saturating at MAX_LEN.
  - `food_eaten` in IDLE or DEAD is dropped.
- Simultaneous events:
  - A step and `food_eaten` in the same cycle are both applied.
  - A dying step and `food_eaten` in the same cycle: the food still counts, then the state is DEAD.

## Timing
- Reset values:
  - `xpos` = START_X, `ypos` = START_Y.
  - `move_tick` = 0.
  - `snake_len` = 1, `score` = 0.
  - `running` = 0, `game_over` = 0.
  - State = IDLE, dir = pend_dir = RIGHT, prescaler = 0, start-edge register = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Step latency:
  - The prescaler reaches TICK_DIV-1 at cycle N.
  - `xpos`/`ypos` show the new value at N+1.
  - `move_tick` is high for exactly cycle N+1.
- Steps occur every TICK_DIV cycles while in RUN. The first step comes TICK_DIV cycles after entering RUN from a reset prescaler.
- `start` edge:
  - A rise at cycle N changes the state at N+2 (one register for edge detection, one for the state).
  - Holding `start` high causes no further transitions.
- `food_eaten` at cycle N appears in `score`/`snake_len` at N+1.
- A button sampled at cycle N affects a step at cycle ≥ N+1.
- A dying step at cycle N: `game_over` = 1 and `running` = 0 at N+1. No `move_tick` is issued.
- Reset asserted mid-RUN: all registers return to their reset values on the next clk edge. An in-flight step is discarded.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - An out-of-range step wraps instead of dying.
  - X: X_MAX+1 → 0, and -1 → X_MAX. Y likewise with Y_MAX.
  - DEAD is unreachable from a step.
  - `move_tick` is issued normally on a wrapping step.
- Undefined: wall exit → DEAD, as in Operation.

## Test plan
Directed tests are built with TICK_DIV=4.
- Reset held 3 cycles, then released → xpos=20, ypos=20, snake_len=1, score=0, running=0. No move_tick for 20 cycles.
- `start` pulse, no buttons → running=1 two cycles later, then xpos 21, 22, 23 on successive ticks spaced 4 cycles apart, ypos=20 throughout.
- In RUN heading RIGHT, press btn_left, then btn_up → left ignored (reversal); next step gives ypos=19. Pressing btn_up and btn_right together gives up.
- `food_eaten` pulses ×65 in RUN → score=65, snake_len=63 (saturated). A pulse in IDLE leaves both unchanged.
- Defaults, START_Y=0, direction UP, one tick → without SNAKE_WRAP_EN: game_over=1, ypos=0. With it: ypos=255, running=1.
- In DEAD, pulse `start` → IDLE, position (20,20), score=0. A second pulse → RUN. Reset asserted mid-RUN at prescaler count 2 → all values return to reset on the next edge.
